// File: rtl/adder_pkg.sv
// adder_pkg: shared constants, op encoding and sizing helpers
// for the pipelined lookahead adder datapath.
package adder_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Bits resolved by one pipeline stage.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Number of 4-bit lookahead groups inside one slice.
    function automatic int group_count(input int width, input int stages);
        return slice_width(width, stages) / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_group_4.sv
// cla_group_4: 4-bit carry-lookahead group producing the sum
// plus group propagate/generate for the next lookahead level.
module cla_group_4
    import adder_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               pg,
    output logic               gg
);

    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] c;

    // PG/GG depend only on the operands so the slice-level
    // lookahead never waits on this group's carry-in.
    assign p  = a ^ b;
    assign g  = a & b;
    assign pg = &p;
    assign gg = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

    // Flattened per-bit carries and the group sum.
    always_comb begin
        c[0] = cin;
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        s    = p ^ c;
    end

endmodule

// File: rtl/pipelined_lookahead_adder.sv
// pipelined_lookahead_adder: valid/ready pipelined lookahead
// adder/subtractor, one operand slice resolved per stage.
module pipelined_lookahead_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE  = slice_width(WIDTH, STAGES);
    localparam int GROUPS = group_count(WIDTH, STAGES);

    logic advance;

    // Operand capture register (B already conditioned, carry-in = op).
    logic             cap_vld_d, cap_vld_q;
    logic             cap_cin_d, cap_cin_q;
    logic [WIDTH-1:0] cap_a_d, cap_a_q;
    logic [WIDTH-1:0] cap_b_d, cap_b_q;

    // Links between pipeline levels: index 0 is the capture register,
    // index k+1 is the register of stage k.
    logic             lnk_vld [STAGES+1];
    logic             lnk_cy  [STAGES+1];
    logic [WIDTH-1:0] lnk_res [STAGES+1];
    logic [WIDTH-1:0] lnk_a   [STAGES+1];
    logic [WIDTH-1:0] lnk_b   [STAGES+1];
    logic             lnk_msb [STAGES];

    // The last stage has no operand bits left to consume.
    logic unused_tail;
    assign unused_tail = ^{lnk_a[STAGES], lnk_b[STAGES]};

    // One global advance: the whole pipe moves unless a result is stuck.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Capture next operand set; a bubble only clears the valid bit.
    always_comb begin
        cap_vld_d = cap_vld_q;
        cap_cin_d = cap_cin_q;
        cap_a_d   = cap_a_q;
        cap_b_d   = cap_b_q;
        if (advance) begin
            cap_vld_d = in_valid;
        end
        if (advance && in_valid) begin
            cap_a_d   = A;
            cap_b_d   = (op_t'(op) == OP_SUB) ? ~B : B;
            cap_cin_d = (op_t'(op) == OP_SUB);
        end
    end

    // Capture register state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cap_vld_q <= 1'b0;
            cap_cin_q <= 1'b0;
            cap_a_q   <= '0;
            cap_b_q   <= '0;
        end else begin
            cap_vld_q <= cap_vld_d;
            cap_cin_q <= cap_cin_d;
            cap_a_q   <= cap_a_d;
            cap_b_q   <= cap_b_d;
        end
    end

    assign lnk_vld[0] = cap_vld_q;
    assign lnk_cy[0]  = cap_cin_q;
    assign lnk_res[0] = '0;
    assign lnk_a[0]   = cap_a_q;
    assign lnk_b[0]   = cap_b_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO_W = SLICE * (k + 1);
        localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << LO_W;

        logic              cin;
        logic [SLICE-1:0]  sa, sb, sum;
        logic [GROUPS-1:0] pg, gg;
        logic [GROUPS:0]   gc;
        logic              t_acc, t_grp;
        logic              vld_d, vld_q;
        logic              cout_d, cout_q;
        logic              cmsb_d, cmsb_q;
        logic [WIDTH-1:0]  res_d, res_q;
        logic [WIDTH-1:0]  a_d, a_q;
        logic [WIDTH-1:0]  b_d, b_q;

        assign cin = lnk_cy[k];
        assign sa  = lnk_a[k][k*SLICE +: SLICE];
        assign sb  = lnk_b[k][k*SLICE +: SLICE];

        for (genvar g = 0; g < GROUPS; g++) begin : g_grp
            cla_group_4 u_grp (
                .a   (sa[g*GROUP_W +: GROUP_W]),
                .b   (sb[g*GROUP_W +: GROUP_W]),
                .cin (gc[g]),
                .s   (sum[g*GROUP_W +: GROUP_W]),
                .pg  (pg[g]),
                .gg  (gg[g])
            );
        end

        // Group carries as flat sums of products of PG/GG and cin.
        always_comb begin
            gc    = '0;
            t_acc = 1'b0;
            t_grp = 1'b0;
            gc[0] = cin;
            for (int j = 0; j < GROUPS; j++) begin
                t_acc = cin;
                for (int i = 0; i <= j; i++) begin
                    t_acc = t_acc & pg[i];
                end
                for (int i = 0; i <= j; i++) begin
                    t_grp = gg[i];
                    for (int m = i + 1; m <= j; m++) begin
                        t_grp = t_grp & pg[m];
                    end
                    t_acc = t_acc | t_grp;
                end
                gc[j+1] = t_acc;
            end
        end

        // Stage update: valid follows the pipe, data loads only for real ops.
        always_comb begin
            vld_d  = vld_q;
            cout_d = cout_q;
            cmsb_d = cmsb_q;
            res_d  = res_q;
            a_d    = a_q;
            b_d    = b_q;
            if (advance) begin
                vld_d = lnk_vld[k];
            end
            if (advance && lnk_vld[k]) begin
                res_d = lnk_res[k];
                res_d[k*SLICE +: SLICE] = sum;
                a_d    = lnk_a[k] & HI_MASK;
                b_d    = lnk_b[k] & HI_MASK;
                cout_d = gc[GROUPS];
                cmsb_d = sum[SLICE-1] ^ sa[SLICE-1] ^ sb[SLICE-1];
            end
        end

        // Stage register state.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                vld_q  <= 1'b0;
                cout_q <= 1'b0;
                cmsb_q <= 1'b0;
                res_q  <= '0;
                a_q    <= '0;
                b_q    <= '0;
            end else begin
                vld_q  <= vld_d;
                cout_q <= cout_d;
                cmsb_q <= cmsb_d;
                res_q  <= res_d;
                a_q    <= a_d;
                b_q    <= b_d;
            end
        end

        assign lnk_vld[k+1] = vld_q;
        assign lnk_cy[k+1]  = cout_q;
        assign lnk_res[k+1] = res_q;
        assign lnk_a[k+1]   = a_q;
        assign lnk_b[k+1]   = b_q;
        assign lnk_msb[k]   = cmsb_q;
    end

    assign out_valid = lnk_vld[STAGES];
    assign S         = lnk_res[STAGES];
    assign cout      = lnk_cy[STAGES];
    assign ovf       = lnk_msb[STAGES-1] ^ lnk_cy[STAGES];

endmodule

// File: tb/tb_pipelined_lookahead_adder.sv
// tb_pipelined_lookahead_adder: scoreboard bench with directed
// corner cases, stall/reset scenarios and random traffic.
module tb_pipelined_lookahead_adder;

    localparam int W      = 16;
    localparam int ST     = 2;
    localparam int N_RAND = 10000;

    logic         Clk       = 1'b0;
    logic         Reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic         op        = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] S;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    res_t exp_q[$];
    res_t mon_exp;
    int   errors = 0;
    int   checks = 0;
    int   n_in   = 0;
    int   n_out  = 0;

    pipelined_lookahead_adder #(
        .WIDTH  (W),
        .STAGES (ST)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 Clk = ~Clk;

    // Reference: plain unsigned/signed arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic sub);
        res_t   e;
        int     sa, sb, r;
        longint ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'(a);
        ub = longint'(b);
        if (sub) begin
            r   = sa - sb;
            e.s = W'(ua - ub);
            e.c = (ua >= ub);
        end else begin
            r   = sa + sb;
            e.s = W'(ua + ub);
            e.c = ((ua + ub) >= (longint'(1) << W));
        end
        e.v = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
        return e;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic sub);
        int budget;
        budget = 0;
        tick();
        in_valid = 1'b1;
        A        = a;
        B        = b;
        op       = sub;
        forever begin
            @(negedge Clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b, sub));
                n_in++;
                break;
            end
            budget++;
            if (budget > 200) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: in_ready stuck at 0");
                break;
            end
            tick();
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 100) begin
            @(negedge Clk);
            #1;
            budget++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Output monitor: every delivered result is popped and compared.
    always @(negedge Clk) begin
        if (!Reset && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got S=%0h expected none", S);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {S, cout, ovf}, mon_exp);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pending;
        int   cyc;

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_S", S, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        tick();
        check("in_ready_after_reset", in_ready, 1);

        out_ready = 1'b1;
        issue(16'hFFFF, 16'h0001, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("latency_edge1", out_valid, 0);
        tick();
        check("latency_edge2", out_valid, 1);
        drain();

        issue(16'h7FFF, 16'h0001, 1'b0);
        issue(16'h00FF, 16'h0001, 1'b0);
        issue(16'h8000, 16'h0001, 1'b1);
        issue(16'h0000, 16'h0001, 1'b1);
        drain();

        issue(16'h0001, 16'h0001, 1'b0);
        issue(16'h0002, 16'h0002, 1'b0);
        issue(16'h0003, 16'h0003, 1'b0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_hold_S", S, 16'h0002);
            if (i < 2) tick();
        end
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("release_no_gap", out_valid, 1);
        end
        @(negedge Clk);
        #1;
        check("release_done", out_valid, 0);
        check("release_queue", exp_q.size(), 0);

        issue(16'h1234, 16'h1111, 1'b0);
        issue(16'hAAAA, 16'h0F0F, 1'b1);
        tick();
        in_valid = 1'b0;
        #2;
        Reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_S", S, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        tick();
        check("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            check("midrst_no_stale", out_valid, 0);
        end

        n_in    = 0;
        n_out   = 0;
        pending = 1'b0;
        cyc     = 0;
        while (n_in < N_RAND && cyc < 60000) begin
            tick();
            cyc++;
            if (!pending) begin
                in_valid = ($urandom_range(0, 9) < 7);
                A        = rand_op();
                B        = rand_op();
                op       = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge Clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(A, B, op));
                n_in++;
                pending = 1'b0;
            end else begin
                pending = in_valid;
            end
        end
        check("rand_in_count", n_in, N_RAND);
        drain();
        check("count_in_out", n_out, n_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_lookahead_adder.md
# pipelined_lookahead_adder

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. Operands are split into STAGES equal slices. Each pipeline stage resolves one slice with group-lookahead logic and registers the inter-slice carry. The block is the datapath adder for wide arithmetic in the lab processor, and it replaces the fixed 4-bit lookahead adder wherever throughput and backpressure matter.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4
- STAGES, 2, pipeline depth; (WIDTH/4) must be divisible by STAGES; SLICE = WIDTH/STAGES
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept this cycle
- A, B  input  WIDTH  operands
- op  input  1  OP_ADD (0): A+B; OP_SUB (1): A+~B+1
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts this cycle
- S  output  WIDTH  sum/difference
- cout  output  1  carry out of MSB; for OP_SUB, 1 = no borrow
- ovf  output  1  signed overflow (carry into MSB XOR cout)

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Global advance = !out_valid || out_ready. in_ready = advance (combinational). All stage registers load only when advance = 1; otherwise every stage holds.
- Stage 0 uses A[SLICE-1:0] and B' (B' = op ? ~B : B). Its carry-in is op.
- Stage k uses slice k of its skewed operand registers and the registered carry from stage k-1.
- Each stage register holds:
  - valid bit
  - completed low result bits
  - remaining high operand bits (A, B' already conditioned)
  - carry out of the slice
  - carry into the slice MSB (used by the last stage for ovf)
- Within a slice, 4-bit groups produce PG/GG. Group carries are resolved with two-level lookahead: c(g+1) = GG(g) | PG(g)&c(g). No ripple between groups.
- Valid bits shift with data, so bubbles propagate. A stage loaded with in_valid = 0 becomes invalid.
- Last stage register drives S, cout, ovf, out_valid directly. Outputs are registered, not combinational.

## Timing
- Reset (async, any time): all stage valid bits = 0; S = 0, cout = 0, ovf = 0, out_valid = 0. in_ready = 1 from the first cycle after reset deassertion.
- Reset asserted mid-operation discards all in-flight operations. No partial result appears afterwards.
- Latency: a result accepted at edge n is presented (out_valid = 1) after edge n+STAGES.
- Throughput: one operation per cycle when out_ready = 1 continuously.
- Stall: with out_valid = 1 and out_ready = 0, in_ready = 0. S/cout/ovf and all internal stages hold. No operation is lost or duplicated, and order is preserved.
- Simultaneous output and input transfer in the same cycle is legal and keeps full throughput.
- When out_valid = 0, S/cout/ovf hold their last value; consumers ignore them.
- Wrap-around: the result is modulo 2^WIDTH; the carry is reported only via cout.

## Structure
- Package adder_pkg:
  - GROUP_W = 4
  - typedef enum logic {OP_ADD, OP_SUB} op_t
  - function computing the slice count from WIDTH/STAGES
- Sub-module cla_group_4:
  - inputs: 4-bit A, B, cin
  - outputs: S, PG, GG
  - SLICE/4 instances per stage, generated
- Stage registers are built as a generate loop over STAGES. Carry and skew arrays are sized from the package constants.

## Test plan
Parameters for all scenarios: WIDTH = 16, STAGES = 2.
- Reset asserted while two ops are in flight -> out_valid = 0 and S = 0 immediately. After release, in_ready = 1 and no stale result ever appears.
- ADD 0xFFFF + 0x0001 -> S = 0x0000, cout = 1, ovf = 0, out_valid exactly 2 cycles after acceptance.
- ADD 0x7FFF + 0x0001 -> S = 0x8000, cout = 0, ovf = 1. ADD 0x00FF + 0x0001 -> S = 0x0100 (carry crosses the slice boundary).
- SUB 0x8000 − 0x0001 -> S = 0x7FFF, cout = 1, ovf = 1. SUB 0x0000 − 0x0001 -> S = 0xFFFF, cout = 0, ovf = 0.
- Stream ops 1+1, 2+2, 3+3 back-to-back with out_ready low for 3 cycles after the first result:
  - in_ready drops while stalled
  - outputs hold at S = 0x0002
  - on release, results 0x0002, 0x0004, 0x0006 appear in order with no gaps
- Random in_valid/out_ready (≥10k ops, both modes) -> every result matches the reference model, in order, with count in = count out.
